// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential multiply-accumulate and its divider partner.
// Holds the default operand width, the FSM state encoding and a counter-width helper.
package alu_pkg;

    localparam int W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width; never below one bit so a degenerate W=1 still has a counter.
    function automatic int cntWidth(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cntWidth(W_DEF);

endpackage

// File: rtl/add_carry_w.sv
// W-bit unsigned adder with carry-out, used for the partial-product step.
module add_carry_w #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul_add_16x16.sv
// Sequential shift-add multiply-accumulate: {ph,pl} = a*b + c, one partial product per clock.
// Results are loaded into ph/pl only on the edge that raises fin, so they hold between operations.
module mul_add_16x16
    import alu_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] ph,
    output logic [W-1:0] pl,
    output logic         busy,
    output logic         fin
);

    localparam int CW = cntWidth(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    state_t        stateNext;
    logic [W-1:0]  accHi;
    logic [W-1:0]  accLo;
    logic [W-1:0]  bReg;
    logic [W-1:0]  addB;
    logic [W-1:0]  sum;
    logic          carry;
    logic [W:0]    s;
    logic [CW-1:0] cnt;
    logic          start;
    logic          lastStep;

    assign addB     = accLo[0] ? bReg : '0;
    assign s        = {carry, sum};
    assign start    = ena && ((state == IDLE) || (state == DONE));
    assign lastStep = (state == RUN) && (cnt == LAST);

    add_carry_w #(
        .W(W)
    ) stepAdder (
        .a   (accHi),
        .b   (addB),
        .sum (sum),
        .cout(carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ena during RUN is deliberately not looked at, so it is neither honoured nor queued.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = ena ? RUN : IDLE;
            RUN:     stateNext = (cnt == LAST) ? DONE : RUN;
            DONE:    stateNext = ena ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        fin  = (state == DONE);
    end

    // The carry s[W] shifts into accHi[W-1]; the bit leaving accHi enters accLo from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            accHi <= '0;
            accLo <= '0;
            bReg  <= '0;
            cnt   <= '0;
            ph    <= '0;
            pl    <= '0;
        end else if (start) begin
            accHi <= c;
            accLo <= a;
            bReg  <= b;
            cnt   <= '0;
        end else if (state == RUN) begin
            accHi <= s[W:1];
            accLo <= {s[0], accLo[W-1:1]};
            cnt   <= cnt + CW'(1);
            if (lastStep) begin
                ph <= s[W:1];
                pl <= {s[0], accLo[W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_mul_add_16x16.sv
// Self-checking bench for mul_add_16x16: vector table, handshake corner cases and a divider round trip.
// Expected products are queued when an operation starts and compared whenever fin pulses.
module tb_mul_add_16x16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] ph;
        logic [15:0] pl;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] ph;
    logic [15:0] pl;
    logic        busy;
    logic        fin;

    int          errors;
    int          checks;
    int          cycle;
    int          finCount;
    logic [31:0] sbQ[$];

    mul_add_16x16 #(.W(16)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .a   (a),
        .b   (b),
        .c   (c),
        .ph  (ph),
        .pl  (pl),
        .busy(busy),
        .fin (fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Scoreboard: every fin must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && fin) begin
            finCount++;
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_fin: got fin=1 with ph/pl 0x%04h%04h, expected no fin", ph, pl);
            end else begin
                checkOutput("scoreboard", {ph, pl}, sbQ.pop_front());
            end
        end
    end

    // Drive one start request for a single clock; returns at the negedge after the start edge.
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic [15:0] vc, input bit push);
        @(negedge clk);
        a   = va;
        b   = vb;
        c   = vc;
        ena = 1'b1;
        if (push) sbQ.push_back(32'(va) * 32'(vb) + 32'(vc));
        @(negedge clk);
        ena = 1'b0;
    endtask

    task automatic waitFin(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fin) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL fin_timeout: got no fin within %0d cycles, expected fin", budget);
        end
    endtask

    initial begin
        vec_t        vecs[7];
        bit          ok;
        int          finAt;
        int          busyCnt;
        int          firstFin;
        int          finBefore;
        logic [31:0] prod;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rc;

        vecs[0] = '{16'h0003, 16'h0005, 16'h0000, 16'h0000, 16'h000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[2] = '{16'h1234, 16'h0000, 16'h00AB, 16'h0000, 16'h00AB};
        vecs[3] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h0000, 16'h1234};
        vecs[4] = '{16'h0100, 16'h0100, 16'h0000, 16'h0001, 16'h0000};
        vecs[5] = '{16'hFFFF, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
        vecs[6] = '{16'h8000, 16'h0002, 16'h0000, 16'h0001, 16'h0000};

        errors   = 0;
        checks   = 0;
        cycle    = 0;
        finCount = 0;
        rst      = 1'b1;
        ena      = 1'b0;
        a        = '0;
        b        = '0;
        c        = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ph_pl", {ph, pl}, 32'h0);
        checkOutput("reset_busy_fin", {30'h0, busy, fin}, 32'h0);
        rst = 1'b0;

        // Latency and busy width: start edge is edge 0, fin visible after edge 16.
        applyStimulus(16'h0003, 16'h0005, 16'h0000, 1'b1);
        finAt   = -1;
        busyCnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (fin) begin
                finAt = k;
                break;
            end
            if (busy) busyCnt++;
            @(negedge clk);
        end
        checkOutput("fin_latency", 32'(finAt), 32'd16);
        checkOutput("busy_cycles", 32'(busyCnt), 32'd16);
        checkOutput("result_3x5", {ph, pl}, 32'h0000_000F);
        @(negedge clk);
        checkOutput("fin_one_pulse", {31'h0, fin}, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
            waitFin(40, ok);
            if (ok) checkOutput($sformatf("vec%0d", i), {ph, pl}, {vecs[i].ph, vecs[i].pl});
            @(negedge clk);
        end

        // ena pulsed mid-run with a different a must be ignored.
        finBefore = finCount;
        applyStimulus(16'h0002, 16'h0003, 16'h0001, 1'b1);
        repeat (4) @(negedge clk);
        a   = 16'h0009;
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        waitFin(40, ok);
        if (ok) checkOutput("ignore_ena_pl", {16'h0, pl}, 32'h0000_0007);
        repeat (25) @(negedge clk);
        checkOutput("ignore_ena_fins", 32'(finCount - finBefore), 32'd1);

        // Reset mid-run aborts with no fin and clears the outputs.
        finBefore = finCount;
        applyStimulus(16'h00FF, 16'h0101, 16'h0000, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ph_pl", {ph, pl}, 32'h0);
        checkOutput("abort_busy_fin", {30'h0, busy, fin}, 32'h0);
        repeat (30) @(negedge clk);
        checkOutput("abort_no_fin", 32'(finCount - finBefore), 32'd0);
        applyStimulus(16'h0001, 16'h0001, 16'h0000, 1'b1);
        waitFin(40, ok);
        if (ok) checkOutput("after_abort_pl", {ph, pl}, 32'h0000_0001);
        @(negedge clk);

        // ena held high: back-to-back restarts from DONE, inputs changed after the first start edge.
        @(negedge clk);
        a   = 16'h0001;
        b   = 16'h0002;
        c   = 16'h0000;
        ena = 1'b1;
        sbQ.push_back(32'h0000_0002);
        @(negedge clk);
        a = 16'h0003;
        b = 16'h0004;
        sbQ.push_back(32'h0000_000C);
        waitFin(40, ok);
        firstFin = cycle;
        if (ok) checkOutput("held_first_pl", {16'h0, pl}, 32'h0000_0002);
        @(negedge clk);
        waitFin(40, ok);
        ena = 1'b0;
        if (ok) begin
            checkOutput("held_second_pl", {16'h0, pl}, 32'h0000_000C);
            checkOutput("held_spacing", 32'(cycle - firstFin), 32'd17);
        end
        repeat (3) @(negedge clk);
        checkOutput("held_stops", {30'h0, busy, fin}, 32'h0);

        // Round trip through a divider model: {ph,pl} / b gives back a, remainder c.
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 16'hFFFF));
            rc = 16'($urandom % 32'(rb));
            applyStimulus(ra, rb, rc, 1'b1);
            waitFin(40, ok);
            if (ok) begin
                prod = {ph, pl};
                checkOutput($sformatf("roundtrip%0d", n),
                            {16'(prod / 32'(rb)), 16'(prod % 32'(rb))}, {ra, rc});
            end
            @(negedge clk);
        end

        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
